// File: rtl/counter_job_arbiter_if.sv
// Job request bundle for two requesters plus the shared counter status returned by the arbiter.
interface counter_job_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic             req0_down;
  logic [WIDTH-1:0] req0_mod;
  logic [LEN_W-1:0] req0_len;
  logic             req1_valid;
  logic             req1_ready;
  logic             req1_down;
  logic [WIDTH-1:0] req1_mod;
  logic [LEN_W-1:0] req1_len;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             owner;
  logic             wrap;
  logic             done0;
  logic             done1;

  modport master (
    output req0_valid, req0_down, req0_mod, req0_len,
    output req1_valid, req1_down, req1_mod, req1_len,
    input  req0_ready, req1_ready,
    input  count, busy, owner, wrap, done0, done1
  );

  modport slave (
    input  req0_valid, req0_down, req0_mod, req0_len,
    input  req1_valid, req1_down, req1_mod, req1_len,
    output req0_ready, req1_ready,
    output count, busy, owner, wrap, done0, done1
  );
endinterface

// File: rtl/counter_job_arbiter.sv
// Round-robin sequencer that owns one up/down mod-N counter and runs one requester job at a time.
module counter_job_arbiter #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  counter_job_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] mod_r;
  logic [LEN_W-1:0] remaining;
  logic             down_r;
  logic             busy;
  logic             owner;
  logic             wrap;
  logic             done0;
  logic             done1;
  logic             prio;

  logic             ready0;
  logic             ready1;
  logic             accept;
  logic             sel_down;
  logic [WIDTH-1:0] sel_mod;
  logic [LEN_W-1:0] sel_len;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  // A requester only loses a tie when the other one holds priority.
  assign ready0   = (state == IDLE) && bus.req0_valid && (!bus.req1_valid || !prio);
  assign ready1   = (state == IDLE) && bus.req1_valid && (!bus.req0_valid ||  prio);
  assign accept   = ready0 || ready1;
  assign sel_down = ready1 ? bus.req1_down : bus.req0_down;
  assign sel_mod  = ready1 ? bus.req1_mod  : bus.req0_mod;
  assign sel_len  = ready1 ? bus.req1_len  : bus.req0_len;

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (down_r) begin
      if (count == '0) begin
        next_count = mod_r;
        next_wrap  = 1'b1;
      end else begin
        next_count = count - WIDTH'(1);
      end
    end else if (count == mod_r) begin
      next_count = '0;
      next_wrap  = 1'b1;
    end else begin
      next_count = count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      mod_r     <= '0;
      remaining <= '0;
      down_r    <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
      wrap      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      prio      <= 1'b0;
    end else begin
      wrap  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            down_r    <= sel_down;
            mod_r     <= sel_mod;
            remaining <= sel_len;
            owner     <= ready1;
            busy      <= 1'b1;
            count     <= sel_down ? sel_mod : '0;
            // A zero-length job skips straight to completion.
            if (sel_len != '0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              done0 <= !ready1;
              done1 <= ready1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          count     <= next_count;
          wrap      <= next_wrap;
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state <= DONE;
            done0 <= !owner;
            done1 <= owner;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          prio  <= !owner;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.count      = count;
  assign bus.busy       = busy;
  assign bus.owner      = owner;
  assign bus.wrap       = wrap;
  assign bus.done0      = done0;
  assign bus.done1      = done1;

endmodule

// File: tb/tb_counter_job_arbiter.sv
// Randomized self-checking bench for counter_job_arbiter against an arithmetic job model.
module tb_counter_job_arbiter;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;

  typedef struct {
    bit idx;
    bit down;
    int mod;
    int len;
  } job_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [WIDTH-1:0] model_count;
  bit   model_prio;

  counter_job_arbiter_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  counter_job_arbiter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value after k steps of a job is a plain position on a ring of mod+1 values.
  function automatic int exp_count(input bit down, input int mod, input int k);
    int r;
    r = k % (mod + 1);
    return down ? (mod - r) : r;
  endfunction

  function automatic bit exp_wrap(input int mod, input int k);
    return (k > 0) && ((k % (mod + 1)) == 0);
  endfunction

  task automatic drive_req(input bit idx, input bit v, input bit d, input int m, input int l);
    if (idx == 1'b0) begin
      bus.req0_valid = v;
      bus.req0_down  = d;
      bus.req0_mod   = WIDTH'(m);
      bus.req0_len   = LEN_W'(l);
    end else begin
      bus.req1_valid = v;
      bus.req1_down  = d;
      bus.req1_mod   = WIDTH'(m);
      bus.req1_len   = LEN_W'(l);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    model_prio  = 1'b0;
    model_count = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 0, 0);
    drive_req(1'b1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.count !== '0 || bus.busy !== 1'b0 || bus.owner !== 1'b0 || bus.wrap !== 1'b0 ||
        bus.done0 !== 1'b0 || bus.done1 !== 1'b0)
      begin bad++; $display("[TB] FAIL reset_state: got count=%0d busy=%0b owner=%0b wrap=%0b done=%0b%0b expected all zero",
                            bus.count, bus.busy, bus.owner, bus.wrap, bus.done0, bus.done1); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.count !== '0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
      begin bad++; $display("[TB] FAIL idle_after_reset: got busy=%0b count=%0d ready=%0b%0b expected 0 0 00",
                            bus.busy, bus.count, bus.req0_ready, bus.req1_ready); end
    model_prio  = 1'b0;
    model_count = '0;
  endtask

  task automatic test_single_jobs();
    job_t jobs[$];
    job_t j;
    logic [WIDTH-1:0] exp_c;
    bit exp_w;
    jobs.push_back('{idx: 1'b0, down: 1'b0, mod: 10, len: 13});
    jobs.push_back('{idx: 1'b1, down: 1'b1, mod: 15, len: 16});
    jobs.push_back('{idx: 1'b0, down: 1'b0, mod: 7,  len: 0});
    jobs.push_back('{idx: 1'b1, down: 1'b0, mod: 0,  len: 3});
    jobs.push_back('{idx: 1'b0, down: 1'b1, mod: 0,  len: 2});
    jobs.push_back('{idx: 1'b1, down: 1'b1, mod: 9,  len: 0});
    for (int r = 0; r < 20; r++) begin
      j.idx  = ($urandom_range(0, 1) == 1);
      j.down = ($urandom_range(0, 1) == 1);
      j.mod  = int'($urandom_range(0, 15));
      j.len  = int'($urandom_range(0, 40));
      jobs.push_back(j);
    end
    foreach (jobs[n]) begin
      j = jobs[n];
      exp_c = WIDTH'(exp_count(j.down, j.mod, 0));
      drive_req(j.idx, 1'b1, j.down, j.mod, j.len);
      #1;
      total++;
      if (bus.req0_ready !== (j.idx == 1'b0) || bus.req1_ready !== (j.idx == 1'b1))
        begin bad++; $display("[TB] FAIL ready job%0d: got %0b%0b expected req%0d only",
                              n, bus.req0_ready, bus.req1_ready, j.idx); end
      @(negedge clk);
      // Scrambled request fields must not disturb the running job.
      drive_req(j.idx, 1'b0, ~j.down, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      for (int k = 0; k <= j.len; k++) begin
        if (k > 0) @(negedge clk);
        exp_c = WIDTH'(exp_count(j.down, j.mod, k));
        exp_w = exp_wrap(j.mod, k);
        total++;
        if (bus.count !== exp_c)
          begin bad++; $display("[TB] FAIL count job%0d step%0d: got %0d expected %0d", n, k, bus.count, exp_c); end
        total++;
        if (bus.wrap !== exp_w)
          begin bad++; $display("[TB] FAIL wrap job%0d step%0d: got %0b expected %0b", n, k, bus.wrap, exp_w); end
        total++;
        if (bus.busy !== 1'b1 || bus.owner !== j.idx)
          begin bad++; $display("[TB] FAIL busy_owner job%0d step%0d: got %0b/%0b expected 1/%0b",
                                n, k, bus.busy, bus.owner, j.idx); end
        total++;
        if (bus.done0 !== (k == j.len && j.idx == 1'b0) || bus.done1 !== (k == j.len && j.idx == 1'b1))
          begin bad++; $display("[TB] FAIL done job%0d step%0d: got %0b%0b (done0 done1) len=%0d idx=%0d",
                                n, k, bus.done0, bus.done1, j.len, j.idx); end
      end
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.wrap !== 1'b0 ||
          bus.count !== exp_c || bus.owner !== j.idx)
        begin bad++; $display("[TB] FAIL post_job%0d: got busy=%0b done=%0b%0b wrap=%0b count=%0d owner=%0b expected 0 00 0 %0d %0b",
                              n, bus.busy, bus.done0, bus.done1, bus.wrap, bus.count, bus.owner, exp_c, j.idx); end
      model_count = exp_c;
      model_prio  = ~j.idx;
    end
  endtask

  task automatic test_round_robin();
    bit exp;
    logic [WIDTH-1:0] exp_c;
    pulse_reset();
    drive_req(1'b0, 1'b1, 1'b0, 5, 2);
    drive_req(1'b1, 1'b1, 1'b1, 12, 2);
    #1;
    for (int g = 0; g < 6; g++) begin
      exp = model_prio;
      total++;
      if (bus.req0_ready !== (exp == 1'b0) || bus.req1_ready !== (exp == 1'b1))
        begin bad++; $display("[TB] FAIL rr_grant%0d: got ready=%0b%0b expected grant to %0d",
                              g, bus.req0_ready, bus.req1_ready, exp); end
      @(negedge clk);
      exp_c = exp ? WIDTH'(12) : WIDTH'(0);
      total++;
      if (bus.owner !== exp || bus.busy !== 1'b1 || bus.count !== exp_c)
        begin bad++; $display("[TB] FAIL rr_load%0d: got owner=%0b busy=%0b count=%0d expected %0b 1 %0d",
                              g, bus.owner, bus.busy, bus.count, exp, exp_c); end
      total++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
        begin bad++; $display("[TB] FAIL rr_ready_busy%0d: got %0b%0b expected 00", g, bus.req0_ready, bus.req1_ready); end
      @(negedge clk);
      total++;
      if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1)
        begin bad++; $display("[TB] FAIL rr_both_ready%0d: got 11 expected at most one", g); end
      @(negedge clk);
      exp_c = exp ? WIDTH'(exp_count(1'b1, 12, 2)) : WIDTH'(exp_count(1'b0, 5, 2));
      total++;
      if (bus.done0 !== (exp == 1'b0) || bus.done1 !== (exp == 1'b1) || bus.count !== exp_c)
        begin bad++; $display("[TB] FAIL rr_done%0d: got done=%0b%0b count=%0d expected owner %0d count %0d",
                              g, bus.done0, bus.done1, bus.count, exp, exp_c); end
      model_prio  = ~exp;
      model_count = exp_c;
      if (g == 5) begin
        drive_req(1'b0, 1'b0, 1'b0, 5, 2);
        drive_req(1'b1, 1'b0, 1'b1, 12, 2);
      end
      @(negedge clk);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.count !== model_count)
      begin bad++; $display("[TB] FAIL rr_end: got busy=%0b count=%0d expected 0 %0d", bus.busy, bus.count, model_count); end
  endtask

  task automatic test_reset_mid_run();
    pulse_reset();
    drive_req(1'b0, 1'b1, 1'b0, 4, 1);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b0, 4, 1);
    repeat (2) @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 9, 20);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b0, 9, 20);
    repeat (5) @(negedge clk);
    total++;
    if (bus.count !== WIDTH'(5))
      begin bad++; $display("[TB] FAIL pre_abort_count: got %0d expected 5", bus.count); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.count !== '0 || bus.busy !== 1'b0 || bus.owner !== 1'b0 || bus.wrap !== 1'b0 ||
        bus.done0 !== 1'b0 || bus.done1 !== 1'b0)
      begin bad++; $display("[TB] FAIL async_abort: got count=%0d busy=%0b owner=%0b wrap=%0b done=%0b%0b expected all zero",
                            bus.count, bus.busy, bus.owner, bus.wrap, bus.done0, bus.done1); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.done0 !== 1'b0 || bus.busy !== 1'b0)
        begin bad++; $display("[TB] FAIL abort_no_done%0d: got done0=%0b busy=%0b expected 0 0", c, bus.done0, bus.busy); end
    end
    rst_n = 1'b1;
    drive_req(1'b0, 1'b1, 1'b0, 3, 4);
    drive_req(1'b1, 1'b1, 1'b1, 7, 4);
    #1;
    total++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      begin bad++; $display("[TB] FAIL prio_after_reset: got ready=%0b%0b expected 10", bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b1, 15, 99);
    drive_req(1'b1, 1'b0, 1'b1, 7, 4);
    total++;
    if (bus.owner !== 1'b0 || bus.count !== '0 || bus.busy !== 1'b1)
      begin bad++; $display("[TB] FAIL reaccept: got owner=%0b count=%0d busy=%0b expected 0 0 1", bus.owner, bus.count, bus.busy); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (bus.count !== WIDTH'(exp_count(1'b0, 3, k)) || bus.done0 !== (k == 4))
        begin bad++; $display("[TB] FAIL reaccept_step%0d: got count=%0d done0=%0b expected %0d %0b",
                              k, bus.count, bus.done0, exp_count(1'b0, 3, k), (k == 4)); end
    end
    @(negedge clk);
    model_count = WIDTH'(exp_count(1'b0, 3, 4));
    model_prio  = 1'b1;
  endtask

  task automatic test_valid_drop();
    for (int r = 0; r < 2; r++) begin
      drive_req(r[0], 1'b1, 1'b1, int'($urandom_range(1, 15)), int'($urandom_range(1, 9)));
      #1;
      total++;
      if ((r == 0 ? bus.req0_ready : bus.req1_ready) !== 1'b1)
        begin bad++; $display("[TB] FAIL drop_ready%0d: got 0 expected 1", r); end
      #2;
      drive_req(r[0], 1'b0, 1'b1, 3, 3);
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.count !== model_count || bus.done0 !== 1'b0 || bus.done1 !== 1'b0)
        begin bad++; $display("[TB] FAIL drop_no_accept%0d: got busy=%0b count=%0d expected 0 %0d",
                              r, bus.busy, bus.count, model_count); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_jobs();
    test_round_robin();
    test_reset_mid_run();
    test_valid_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
